lag_window_fsm: RTL

//  Consumer of the packed autocorrelation words r[0..M] that autocorrFSM writes at AUTOCORR_R.

---
 rtl/lag_window_fsm_pkg.sv | 54 +++++
 rtl/lag_window_fsm_memory.sv | 34 +++
 rtl/lag_window_fsm.sv | 109 ++++++++++
 3 files changed

// File: rtl/lag_window_fsm_pkg.sv
// ============================================================================
// Package : lag_window_fsm_pkg
// Brief   : Shared constants, state encoding and ITU basic-operator helpers
//           for the G.729 lag-window stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lag_window_fsm_pkg;

  localparam logic [10:0] AUTOCORR_R = 11'h100;
  localparam logic [7:0]  LW_ORDER   = 8'd10;

  typedef enum logic [2:0] {
    LW_IDLE    = 3'd0,
    LW_RD_REQ  = 3'd1,
    LW_RD_WAIT = 3'd2,
    LW_CALC    = 3'd3,
    LW_WR      = 3'd4,
    LW_FIN     = 3'd5
  } lw_state_t;

  // Saturating 32-bit add (L_add)
  function automatic logic signed [31:0] l_add(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [31:0] s;
    s = a + b;
    if ((a[31] == b[31]) && (s[31] != a[31]))
      return a[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return s;
  endfunction

  function automatic logic signed [31:0] l_mult(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic signed [31:0] p;
    if ((a == 16'sh8000) && (b == 16'sh8000))
      return 32'sh7FFF_FFFF;
    p = a * b;
    return p <<< 1;
  endfunction

  function automatic logic signed [15:0] mult(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    p = p >>> 15;
    if (p > 32'sd32767)
      return 16'sh7FFF;
    return p[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/lag_window_fsm_memory.sv
// ============================================================================
// Module : lag_window_fsm_memory
// Brief  : Combinational lag-window ROM, index (i-1) -> {lag_h, lag_l}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lag_window_fsm_memory (
  input  logic        [3:0]  index,
  output logic signed [15:0] lag_h,
  output logic signed [15:0] lag_l
);

  always_comb begin
    lag_h = '0;
    lag_l = '0;
    case (index)
      4'd0: begin lag_h = 16'sd32728; lag_l = 16'sd11904; end
      4'd1: begin lag_h = 16'sd32619; lag_l = 16'sd17280; end
      4'd2: begin lag_h = 16'sd32438; lag_l = 16'sd30720; end
      4'd3: begin lag_h = 16'sd32187; lag_l = 16'sd25856; end
      4'd4: begin lag_h = 16'sd31867; lag_l = 16'sd24192; end
      4'd5: begin lag_h = 16'sd31480; lag_l = 16'sd28992; end
      4'd6: begin lag_h = 16'sd31029; lag_l = 16'sd24384; end
      4'd7: begin lag_h = 16'sd30517; lag_l = 16'sd7360;  end
      4'd8: begin lag_h = 16'sd29946; lag_l = 16'sd19520; end
      4'd9: begin lag_h = 16'sd29321; lag_l = 16'sd14784; end
      default: begin lag_h = '0; lag_l = '0; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lag_window_fsm.sv
// ============================================================================
// Module : lag_window_fsm
// Brief  : In-place G.729 lag window over r[1..M] on the scratch memory bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lag_window_fsm
  import lag_window_fsm_pkg::*;
#(
  parameter logic [7:0] M = LW_ORDER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [31:0] memIn,
  output logic [10:0] readRequested,
  output logic [10:0] writeRequested,
  output logic [31:0] memOut,
  output logic        writeEn,
  output logic        done
);

  lw_state_t          r_state;
  lw_state_t          w_state_next;
  logic        [7:0]  r_i;
  logic signed [15:0] r_hi1;
  logic signed [15:0] r_lo1;
  logic        [31:0] r_word;

  logic signed [15:0] w_lag_h;
  logic signed [15:0] w_lag_l;
  logic signed [31:0] w_x;
  logic        [31:0] w_word;

  lag_window_fsm_memory u_lag_rom (
    .index (r_i[3:0] - 4'd1),
    .lag_h (w_lag_h),
    .lag_l (w_lag_l)
  );

  // Mpy_32: lo1 is treated as signed, matching the reference C-code
  assign w_x = l_add(l_add(l_mult(r_hi1, w_lag_h),
                           l_mult(mult(r_hi1, w_lag_l), 16'sd1)),
                     l_mult(mult(r_lo1, w_lag_h), 16'sd1));

  // L_Extract packing: low half is x[15:1] with a cleared sign bit
  assign w_word = {w_x[31:16], w_x[15:0] >> 1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LW_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i    <= 8'd1;
      r_hi1  <= '0;
      r_lo1  <= '0;
      r_word <= '0;
    end else begin
      case (r_state)
        LW_IDLE:    if (ready) r_i <= 8'd1;
        LW_RD_WAIT: begin
          r_hi1 <= memIn[31:16];
          r_lo1 <= memIn[15:0];
        end
        LW_CALC:    r_word <= w_word;
        LW_WR:      if (r_i != M) r_i <= r_i + 8'd1;
        default:    ;
      endcase
    end
  end

  always_comb begin
    w_state_next   = r_state;
    readRequested  = '0;
    writeRequested = '0;
    memOut         = '0;
    writeEn        = 1'b0;
    done           = 1'b0;
    case (r_state)
      LW_IDLE:    if (ready) w_state_next = LW_RD_REQ;
      LW_RD_REQ: begin
        readRequested = {AUTOCORR_R[10:8], r_i};
        w_state_next  = LW_RD_WAIT;
      end
      LW_RD_WAIT: begin
        readRequested = {AUTOCORR_R[10:8], r_i};
        w_state_next  = LW_CALC;
      end
      LW_CALC:    w_state_next = LW_WR;
      LW_WR: begin
        writeEn        = 1'b1;
        writeRequested = {AUTOCORR_R[10:8], r_i};
        memOut         = r_word;
        w_state_next   = (r_i == M) ? LW_FIN : LW_RD_REQ;
      end
      LW_FIN: begin
        done         = 1'b1;
        w_state_next = LW_IDLE;
      end
      default:    w_state_next = LW_IDLE;
    endcase
  end

endmodule

`default_nettype wire
